// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus constants: request-line count, select width and register indices.
// The decoder side and the select encoder both use these.
package cpu_bus_pkg;

   localparam int unsigned N_IN  = 16;
   localparam int unsigned SEL_W = $clog2(N_IN);
   localparam int unsigned CNT_W = 8;

   localparam logic [SEL_W-1:0] R0  = SEL_W'(0);
   localparam logic [SEL_W-1:0] R1  = SEL_W'(1);
   localparam logic [SEL_W-1:0] R2  = SEL_W'(2);
   localparam logic [SEL_W-1:0] R3  = SEL_W'(3);
   localparam logic [SEL_W-1:0] R4  = SEL_W'(4);
   localparam logic [SEL_W-1:0] R5  = SEL_W'(5);
   localparam logic [SEL_W-1:0] R6  = SEL_W'(6);
   localparam logic [SEL_W-1:0] R7  = SEL_W'(7);
   localparam logic [SEL_W-1:0] R8  = SEL_W'(8);
   localparam logic [SEL_W-1:0] R9  = SEL_W'(9);
   localparam logic [SEL_W-1:0] R10 = SEL_W'(10);
   localparam logic [SEL_W-1:0] R11 = SEL_W'(11);
   localparam logic [SEL_W-1:0] R12 = SEL_W'(12);
   localparam logic [SEL_W-1:0] R13 = SEL_W'(13);
   localparam logic [SEL_W-1:0] R14 = SEL_W'(14);
   localparam logic [SEL_W-1:0] R15 = SEL_W'(15);

   // Classification of one accepted request word.
   typedef enum logic [1:0] {
      REQ_ONEHOT = 2'b00,
      REQ_NONE   = 2'b01,
      REQ_MULTI  = 2'b10
   } req_kind_t;

   // 4-to-16 register-select decode, the inverse of the encoder.
   function automatic logic [N_IN-1:0] reg_decode(input logic [SEL_W-1:0] code);
      logic [N_IN-1:0] onehot;
      onehot       = '0;
      onehot[code] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational highest-index priority encoder with zero-hot / multi-hot flags.
module prio_enc_comb #(
   parameter int unsigned N_IN  = 16,
   parameter int unsigned SEL_W = 4
) (
   input  logic [N_IN-1:0]  req,
   output logic [SEL_W-1:0] sel,
   output logic             none,
   output logic             multi
);

   logic seen;

   // Ascending scan: later (higher) set bits overwrite sel, so the highest wins.
   always_comb begin
      sel   = '0;
      seen  = 1'b0;
      multi = 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (req[i]) begin
            if (seen) multi = 1'b1;
            seen = 1'b1;
            sel  = SEL_W'(i);
         end
      end
      none = !seen;
   end

endmodule

// File: rtl/bus_select_encoder.sv
// One-hot bus-drive requests to registered binary select code, with valid/ready
// handshake, one-entry output register and saturating malformed-request counter.
module bus_select_encoder #(
   parameter int unsigned N_IN  = cpu_bus_pkg::N_IN,
   parameter int unsigned SEL_W = cpu_bus_pkg::SEL_W,
   parameter int unsigned CNT_W = cpu_bus_pkg::CNT_W
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [N_IN-1:0]  req,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [SEL_W-1:0] sel,
   output logic             none,
   output logic             multi,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clr_err,
   output logic [CNT_W-1:0] err_count
);

   logic [N_IN-1:0]  req_gated;
   logic [SEL_W-1:0] enc_sel;
   logic             enc_none;
   logic             enc_multi;
   logic             accept;
   logic             bad_req;

   // Gating keeps an undriven req from reaching any register when in_valid is low.
   assign req_gated = in_valid ? req : '0;

   prio_enc_comb #(
      .N_IN  (N_IN),
      .SEL_W (SEL_W)
   ) u_enc (
      .req   (req_gated),
      .sel   (enc_sel),
      .none  (enc_none),
      .multi (enc_multi)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign bad_req  = accept && (enc_none || enc_multi);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         sel       <= '0;
         none      <= 1'b0;
         multi     <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         sel       <= enc_sel;
         none      <= enc_none;
         multi     <= enc_multi;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= '0;
      end else if (bad_req && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_select_encoder.sv
// Self-checking bench for bus_select_encoder: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_bus_select_encoder;
   import cpu_bus_pkg::*;

   logic             clock = 1'b0;
   logic             clear;
   logic [N_IN-1:0]  req;
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel;
   logic             none;
   logic             multi;
   logic             out_valid;
   logic             out_ready;
   logic             clr_err;
   logic [CNT_W-1:0] err_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic             m_valid;
   int               m_sel;
   logic             m_none;
   logic             m_multi;
   int               m_err;

   always #5 clock = ~clock;

   bus_select_encoder #(
      .N_IN  (N_IN),
      .SEL_W (SEL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .req       (req),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .none      (none),
      .multi     (multi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .clr_err   (clr_err),
      .err_count (err_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int highest_index(input logic [N_IN-1:0] r);
      for (int i = N_IN - 1; i >= 0; i--)
         if (r[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_sel = 0; m_none = 1'b0; m_multi = 1'b0; m_err = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".sel"},       32'(sel),       32'(m_sel));
      check({tag, ".none"},      32'(none),      32'(m_none));
      check({tag, ".multi"},     32'(multi),     32'(m_multi));
      check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
   endtask

   // Let inputs settle, check in_ready, advance one edge, update model, check outputs.
   task automatic tick(input string tag);
      logic acc;
      #1;
      if (!clear) begin
         @(posedge clock);
         #1;
         model_reset();
         check_outputs(tag);
         return;
      end
      check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
      acc = in_valid && (!m_valid || out_ready);
      @(posedge clock);
      #1;
      if (acc) begin
         m_valid = 1'b1;
         m_sel   = highest_index(req);
         m_none  = (req == '0);
         m_multi = ($countones(req) > 1);
         if ((m_none || m_multi) && m_err < (2 ** CNT_W) - 1) m_err++;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      if (clr_err) m_err = 0;
      check_outputs(tag);
   endtask

   initial begin
      logic [N_IN-1:0] prev_req;
      logic [N_IN-1:0] dec;
      model_reset();
      clear = 1'b0; in_valid = 1'b1; req = 16'h0040; out_ready = 1'b1; clr_err = 1'b0;

      // 1. reset held with a valid request pending, then release
      tick("rst_hold0");
      tick("rst_hold1");
      clear = 1'b1;
      tick("rst_release");
      check("rst_release.sel6", 32'(sel), 32'(R6));

      // 2. one-hot sweep, back-to-back, with decoder round trip
      for (int i = 0; i < N_IN; i++) begin
         req = N_IN'(1) << i;
         prev_req = req;
         tick("sweep");
         dec = reg_decode(sel);
         check("sweep.roundtrip", 32'(dec), 32'(prev_req));
      end

      // 3. stall: held result not overwritten while out_ready=0
      req = 16'h0100; out_ready = 1'b1;
      tick("stall_load");
      out_ready = 1'b0; req = 16'h0002;
      for (int i = 0; i < 3; i++) begin
         tick("stall_hold");
         check("stall_hold.in_ready0", 32'(in_ready), 32'(0));
      end
      out_ready = 1'b1;
      tick("stall_release");

      // 4. malformed requests
      clr_err = 1'b1; in_valid = 1'b0; req = 'x;
      tick("err_clear");
      clr_err = 1'b0; in_valid = 1'b1;
      req = 16'h0000;
      tick("zero_hot");
      req = 16'h8001;
      tick("multi_hot");
      check("multi_hot.err2", 32'(err_count), 32'(2));

      // 5. saturation then clear overriding an increment
      req = 16'h0300;
      for (int i = 0; i < 300; i++) tick("saturate");
      check("saturate.max", 32'(err_count), 32'(255));
      clr_err = 1'b1; req = 16'hC000;
      tick("clr_overrides");
      clr_err = 1'b0;

      // 6. asynchronous reset in the middle of a stall
      req = 16'h0020; out_ready = 1'b1;
      tick("async_load");
      out_ready = 1'b0; in_valid = 1'b0; req = 'x;
      tick("async_stall");
      #2 clear = 1'b0;
      #1;
      model_reset();
      check("async.out_valid", 32'(out_valid), 32'(0));
      check("async.sel",       32'(sel),       32'(0));
      check("async.err_count", 32'(err_count), 32'(0));
      #1 clear = 1'b1;
      @(posedge clock); #1;
      check_outputs("async_after");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_err   = ($urandom_range(0, 31) == 0);
         case ($urandom_range(0, 3))
            0:       req = N_IN'(1) << $urandom_range(0, N_IN - 1);
            1:       req = '0;
            default: req = N_IN'($urandom);
         endcase
         if (!in_valid && $urandom_range(0, 1) == 1) req = 'x;
         tick("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
